bin2bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-add-3, one bit per clock) that produces the

---
 rtl/bin2bcd_seq_pkg.sv | 16 +
 rtl/bin2bcd_seq_bcd_digit_adj.sv | 17 +
 rtl/bin2bcd_seq.sv | 115 +++++++++++
 tb/tb_bin2bcd_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
// The segment driver imports the same package so both blocks agree on digit layout.
package bin2bcd_seq_pkg;

    localparam int unsigned DIN_W_DEF   = 20;
    localparam int unsigned DIGITS_DEF  = 6;
    localparam int unsigned MAX_VAL_DEF = 999999;
    localparam int unsigned BCD_DIG_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage : bin2bcd_seq_pkg

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// One BCD digit of the shift-add-3 step: digits of 5 or more get +3 so that the
// following left shift carries correctly into the next decade.
module bcd_digit_adj
    import bin2bcd_seq_pkg::*;
(
    input  logic [BCD_DIG_W-1:0] digit_in,
    output logic [BCD_DIG_W-1:0] digit_out_c
);

    always_comb begin
        digit_out_c = digit_in;
        if (digit_in >= BCD_DIG_W'(5)) begin
            digit_out_c = digit_in + BCD_DIG_W'(3);
        end
    end

endmodule : bcd_digit_adj

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one bit per clock, saturating at MAX_VAL.
// Produces a packed BCD word plus a one-cycle data_vld strobe for the segment driver.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int unsigned DIN_W   = DIN_W_DEF,
    parameter int unsigned DIGITS  = DIGITS_DEF,
    parameter int unsigned MAX_VAL = MAX_VAL_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        din_vld,
    input  logic [DIN_W-1:0]            din,
    output logic                        busy,
    output logic                        data_vld,
    output logic [BCD_DIG_W*DIGITS-1:0] display_data,
    output logic                        overflow
);

    localparam int unsigned CNT_W = $clog2(DIN_W);
    localparam int unsigned BCD_W = BCD_DIG_W * DIGITS;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{4'h9}};
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(DIN_W - 1);
    localparam logic [DIN_W-1:0] MAX_BIN   = DIN_W'(MAX_VAL);

    state_e             state_q, state_d;
    logic [DIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [BCD_W-1:0]   bcd_adj_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sat_q, sat_d;
    logic [BCD_W-1:0]   disp_q, disp_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               vld_q, vld_d;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_in    (bcd_q[BCD_DIG_W*g +: BCD_DIG_W]),
            .digit_out_c (bcd_adj_c[BCD_DIG_W*g +: BCD_DIG_W])
        );
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        disp_d  = disp_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (din_vld) begin
                    bin_d   = din;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    sat_d   = (din > MAX_BIN);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
                cnt_d          = cnt_q + CNT_W'(1);
                // Final shift: publish the freshly shifted word on entry to DONE.
                if (cnt_q == LAST_CNT) begin
                    state_d = ST_DONE;
                    disp_d  = sat_q ? ALL_NINES : bcd_d;
                    ovf_d   = sat_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        vld_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            disp_q  <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            disp_q  <= disp_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            vld_q   <= vld_d;
        end
    end

    assign busy         = busy_q;
    assign data_vld     = vld_q;
    assign display_data = disp_q;
    assign overflow     = ovf_q;

endmodule : bin2bcd_seq

// File: tb/tb_bin2bcd_seq.sv
// Directed and random checks for bin2bcd_seq: vector table, busy-drop, reset abort, sweep.
module tb_bin2bcd_seq;

    localparam int unsigned DIN_W    = 20;
    localparam int unsigned DIGITS   = 6;
    localparam int unsigned BCD_W    = 4 * DIGITS;
    localparam int          LAT      = DIN_W;
    localparam int          N_SWEEP  = 2500;

    logic               clk;
    logic               rst_n;
    logic               din_vld;
    logic [DIN_W-1:0]   din;
    logic               busy;
    logic               data_vld;
    logic [BCD_W-1:0]   display_data;
    logic               overflow;

    int tests = 0;
    int fails = 0;
    int vld_total = 0;

    typedef struct {
        logic [DIN_W-1:0] din;
        logic [BCD_W-1:0] exp_bcd;
        logic             exp_ovf;
    } vec_t;

    bin2bcd_seq #(.DIN_W(DIN_W), .DIGITS(DIGITS), .MAX_VAL(999999)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_vld      (din_vld),
        .din          (din),
        .busy         (busy),
        .data_vld     (data_vld),
        .display_data (display_data),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (data_vld) vld_total <= vld_total + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [BCD_W-1:0] gold(input int unsigned v);
        logic [BCD_W-1:0] r;
        int unsigned      x;
        x = (v > 999999) ? 999999 : v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Called with DUT idle, #1 after a rising edge; leaves DUT idle likewise.
    task automatic convert(input logic [DIN_W-1:0] v, input logic [BCD_W-1:0] exp_d,
                           input logic exp_o, input string nm);
        int busy_cnt;
        int vld_cnt;
        int vld_at;
        busy_cnt = 0;
        vld_cnt  = 0;
        vld_at   = -1;
        din      = v;
        din_vld  = 1'b1;
        @(posedge clk); #1;
        din_vld  = 1'b0;
        for (int j = 0; j < LAT + 10; j++) begin
            if (busy) busy_cnt++;
            if (data_vld) begin
                vld_cnt++;
                vld_at = j;
                chk({nm, " data"}, 32'(display_data), 32'(exp_d));
                chk({nm, " ovf"}, 32'(overflow), 32'(exp_o));
            end
            @(posedge clk); #1;
        end
        chk({nm, " busy_cycles"}, 32'(busy_cnt), 32'(LAT + 1));
        chk({nm, " strobe_count"}, 32'(vld_cnt), 32'd1);
        chk({nm, " strobe_cycle"}, 32'(vld_at), 32'(LAT));
        chk({nm, " data_hold"}, 32'(display_data), 32'(exp_d));
    endtask

    initial begin
        vec_t vecs[13];
        int   vld_cnt;
        int   j;
        int   base;
        logic [DIN_W-1:0] r;

        vecs[0]  = '{20'd0,       24'h000000, 1'b0};
        vecs[1]  = '{20'd123456,  24'h123456, 1'b0};
        vecs[2]  = '{20'd999999,  24'h999999, 1'b0};
        vecs[3]  = '{20'd1000000, 24'h999999, 1'b1};
        vecs[4]  = '{20'hFFFFF,   24'h999999, 1'b1};
        vecs[5]  = '{20'd42,      24'h000042, 1'b0};
        vecs[6]  = '{20'd1,       24'h000001, 1'b0};
        vecs[7]  = '{20'd9,       24'h000009, 1'b0};
        vecs[8]  = '{20'd10,      24'h000010, 1'b0};
        vecs[9]  = '{20'd99999,   24'h099999, 1'b0};
        vecs[10] = '{20'd500000,  24'h500000, 1'b0};
        vecs[11] = '{20'd65535,   24'h065535, 1'b0};
        vecs[12] = '{20'd524288,  24'h524288, 1'b0};

        rst_n   = 1'b0;
        din_vld = 1'b0;
        din     = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset vld", 32'(data_vld), 32'd0);
        chk("reset data", 32'(display_data), 32'd0);
        chk("reset ovf", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            convert(vecs[i].din, vecs[i].exp_bcd, vecs[i].exp_ovf, $sformatf("vec%0d", i));
        end

        // din_vld held high while busy: only the first value converts.
        din     = 20'd5;
        din_vld = 1'b1;
        @(posedge clk); #1;
        din     = 20'd777;
        vld_cnt = 0;
        for (int k = 0; k <= LAT; k++) begin
            if (data_vld) begin
                vld_cnt++;
                chk("drop data", 32'(display_data), 32'h000005);
                chk("drop strobe_cycle", 32'(k), 32'(LAT));
            end
            if (k < LAT) begin
                @(posedge clk); #1;
            end
        end
        chk("drop strobe_count", 32'(vld_cnt), 32'd1);
        @(posedge clk); #1;
        chk("drop idle_gap", 32'(busy), 32'd0);
        @(posedge clk); #1;
        din_vld = 1'b0;
        chk("drop reaccept", 32'(busy), 32'd1);
        j = 0;
        while (!data_vld && j < LAT + 5) begin
            @(posedge clk); #1;
            j++;
        end
        chk("second strobe_cycle", 32'(j), 32'(LAT));
        chk("second data", 32'(display_data), 32'h000777);
        @(posedge clk); #1;

        // Reset in the middle of SHIFT (cnt == 10) aborts without a strobe.
        din     = 20'd123;
        din_vld = 1'b1;
        @(posedge clk); #1;
        din_vld = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        base  = vld_total;
        rst_n = 1'b0;
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort data", 32'(display_data), 32'd0);
        chk("abort ovf", 32'(overflow), 32'd0);
        chk("abort vld", 32'(data_vld), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (LAT + 5) begin
            @(posedge clk); #1;
        end
        chk("abort no_strobe", 32'(vld_total - base), 32'd0);
        convert(20'd31415, 24'h031415, 1'b0, "post_reset");

        // Random sweep against the golden model.
        base = vld_total;
        for (int n = 0; n < N_SWEEP; n++) begin
            r       = DIN_W'($urandom_range(0, 32'hFFFFF));
            din     = r;
            din_vld = 1'b1;
            @(posedge clk); #1;
            din_vld = 1'b0;
            j = 0;
            while (!data_vld && j < LAT + 5) begin
                @(posedge clk); #1;
                j++;
            end
            if (!data_vld) begin
                chk("sweep timeout", 32'(j), 32'(LAT));
            end else begin
                chk($sformatf("sweep data din=%0d", r), 32'(display_data), 32'(gold(32'(r))));
                chk("sweep ovf", 32'(overflow), 32'(r > 20'd999999));
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        chk("sweep strobe_total", 32'(vld_total - base), 32'(N_SWEEP));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_bin2bcd_seq
